inst_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of icache. Owns the PC, presents it to icache
//  as the lookup address and forwards hits to the IF/ID register. On a miss it fetches the
//  4 instruction bytes from the byte-wide memory controller, assembles them little-endian,

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/inst_word_assembler.sv | 68 ++++++
 rtl/inst_fetch.sv | 134 +++++++++++++
 tb/tb_inst_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC and
// the fetch FSM encoding.
package inst_fetch_pkg;

   localparam int unsigned IF_ADDR_W   = 32;
   localparam int unsigned IF_INST_W   = 32;
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t StLookup = 2'd0;
   localparam fetch_state_t StMiss   = 2'd1;
   localparam fetch_state_t StFill   = 2'd2;
   localparam fetch_state_t StAbort  = 2'd3;

endpackage

// File: rtl/inst_word_assembler.sv
// Miss handling datapath: issues four byte reads, assembles the little-endian word and
// drains responses still in flight after a redirect.
module inst_word_assembler
   import inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W,
   parameter int unsigned INST_W = IF_INST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              miss_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [INST_W-1:0] word_o,
   output logic              done_o,
   output logic [2:0]        outstanding_o
);

   logic [2:0]        issued_q, issued_d;
   logic [2:0]        recv_q, recv_d;
   logic [INST_W-1:0] buf_q, buf_d;
   logic              accept;
   logic              rv;

   assign mem_req_o  = miss_i && (issued_q < 3'd4);
   assign mem_addr_o = pc_i + ADDR_W'(issued_q);
   assign accept     = mem_req_o && mem_gnt_i;
   // A response with nothing outstanding is a protocol error and is dropped.
   assign rv         = mem_rvalid_i && (issued_q != recv_q) && (miss_i || abort_i);

   always_comb begin
      issued_d = issued_q;
      recv_d   = recv_q;
      buf_d    = buf_q;
      if (start_i) begin
         issued_d = '0;
         recv_d   = '0;
      end else begin
         if (accept) issued_d = issued_q + 3'd1;
         if (rv)     recv_d   = recv_q + 3'd1;
         if (rv && miss_i) buf_d[{recv_q[1:0], 3'b000} +: 8] = mem_rdata_i;
      end
   end

   assign done_o        = miss_i && rv && (recv_q == 3'd3);
   // Post-edge count, so a grant or response in the redirect cycle is accounted for.
   assign outstanding_o = issued_d - recv_d;
   assign word_o        = buf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_q <= '0;
         recv_q   <= '0;
         buf_q    <= '0;
      end else begin
         issued_q <= issued_d;
         recv_q   <= recv_d;
         buf_q    <= buf_d;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, looks it up in the icache, refills misses from
// the byte-wide memory and delivers instructions to IF/ID with stall and flush.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = IF_ADDR_W,
   parameter int unsigned       INST_W   = IF_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] cache_addr_o,
   input  logic [INST_W-1:0] cache_data_i,
   input  logic              cache_hit_i,
   output logic              cache_replace_o,
   output logic [INST_W-1:0] cache_wdata_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_valid_o
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic              valid_q, valid_d;
   logic              start;
   logic              done;
   logic [2:0]        outstanding;
   logic [ADDR_W-1:0] target_aligned;

   assign target_aligned = target_i & ~ADDR_W'(3);

   inst_word_assembler #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_assembler (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .miss_i        (state_q == StMiss),
      .abort_i       (state_q == StAbort),
      .pc_i          (pc_q),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .word_o        (cache_wdata_o),
      .done_o        (done),
      .outstanding_o (outstanding)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      start     = 1'b0;
      case (state_q)
         StLookup: begin
            if (flush_i) begin
               pc_d    = target_aligned;
               valid_d = 1'b0;
            end else if (!stall_i) begin
               if (cache_hit_i) begin
                  inst_d    = cache_data_i;
                  inst_pc_d = pc_q;
                  valid_d   = 1'b1;
                  pc_d      = pc_q + ADDR_W'(4);
               end else begin
                  valid_d = 1'b0;
                  start   = 1'b1;
                  state_d = StMiss;
               end
            end
         end
         StMiss: begin
            if (flush_i) begin
               pc_d    = target_aligned;
               valid_d = 1'b0;
               state_d = (outstanding != 3'd0) ? StAbort : StLookup;
            end else if (done) begin
               state_d = StFill;
            end
         end
         StFill: begin
            // The replace still commits on a flush: the word matches its own address.
            state_d = StLookup;
            if (flush_i) begin
               pc_d    = target_aligned;
               valid_d = 1'b0;
            end
         end
         StAbort: begin
            if (flush_i) pc_d = target_aligned;
            if (outstanding == 3'd0) state_d = StLookup;
         end
         default: state_d = StLookup;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StLookup;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
      end
   end

   assign cache_addr_o    = pc_q;
   assign cache_replace_o = (state_q == StFill);
   assign inst_o          = inst_q;
   assign inst_pc_o       = inst_pc_q;
   assign inst_valid_o    = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small direct-mapped icache model and a byte
// memory model whose grant and response timing the stimulus controls.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] target;
   logic [31:0] cache_addr;
   logic [31:0] cache_data;
   logic        cache_hit;
   logic        cache_replace;
   logic [31:0] cache_wdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;

   int n_chk = 0;
   int n_err = 0;

   inst_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .flush_i         (flush),
      .target_i        (target),
      .cache_addr_o    (cache_addr),
      .cache_data_i    (cache_data),
      .cache_hit_i     (cache_hit),
      .cache_replace_o (cache_replace),
      .cache_wdata_o   (cache_wdata),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_gnt_i       (mem_gnt),
      .mem_rvalid_i    (mem_rvalid),
      .mem_rdata_i     (mem_rdata),
      .inst_o          (inst),
      .inst_pc_o       (inst_pc),
      .inst_valid_o    (inst_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // icache model: 8 direct-mapped entries, or a forced hit returning 0x13
   logic        all_hit;
   logic        cache_clr;
   logic [31:0] c_tag [8];
   logic [31:0] c_dat [8];
   logic        c_val [8];
   int          rep_cnt;
   logic [31:0] rep_addr;
   logic [31:0] rep_data;
   logic [2:0]  cidx;

   assign cidx       = cache_addr[4:2];
   assign cache_hit  = all_hit || (c_val[cidx] && (c_tag[cidx] == cache_addr));
   assign cache_data = all_hit ? 32'h0000_0013 : c_dat[cidx];

   always @(posedge clk) begin
      if (cache_clr) begin
         for (int i = 0; i < 8; i++) c_val[i] <= 1'b0;
         rep_cnt <= 0;
      end else if (cache_replace) begin
         c_val[cidx] <= 1'b1;
         c_tag[cidx] <= cache_addr;
         c_dat[cidx] <= cache_wdata;
         rep_cnt     <= rep_cnt + 1;
         rep_addr    <= cache_addr;
         rep_data    <= cache_wdata;
      end
   end

   // memory model: 1-cycle latency, responses held back while mem_hold is set
   logic        mem_hold;
   logic [31:0] pend[$];
   logic [31:0] memlog[$];

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h93;
         32'h101: return 8'h00;
         32'h102: return 8'h10;
         32'h103: return 8'h00;
         default: return a[7:0] + 8'h11;
      endcase
   endfunction

   initial begin
      logic [31:0] a;
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_req && mem_gnt && !rst) begin
            pend.push_back(mem_addr);
            memlog.push_back(mem_addr);
         end
         @(posedge clk);
         #2;
         if (!mem_hold && pend.size() > 0) begin
            a          = pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_byte(a);
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!inst_valid && n < max);
   endtask

   initial begin
      int n;
      int r0;
      rst       = 1'b1;
      cache_clr = 1'b1;
      all_hit   = 1'b1;
      stall     = 1'b0;
      flush     = 1'b0;
      target    = 32'h0;
      mem_gnt   = 1'b1;
      mem_hold  = 1'b0;
      repeat (2) cyc();

      // reset state
      check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
      check_eq("rst_inst", inst, 32'h0);
      check_eq("rst_inst_pc", inst_pc, 32'h0);
      check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check_eq("rst_replace", {31'b0, cache_replace}, 32'd0);
      check_eq("rst_pc", cache_addr, 32'h0);

      // consecutive hits
      rst       = 1'b0;
      cache_clr = 1'b0;
      cyc();
      check_eq("hit0_valid", {31'b0, inst_valid}, 32'd1);
      check_eq("hit0_inst", inst, 32'h13);
      check_eq("hit0_pc", inst_pc, 32'h0);
      cyc();
      check_eq("hit1_pc", inst_pc, 32'h4);
      cyc();
      check_eq("hit2_pc", inst_pc, 32'h8);
      check_eq("hit2_next", cache_addr, 32'hC);

      // redirect to 0x100, then miss and refill
      all_hit = 1'b0;
      flush   = 1'b1;
      target  = 32'h100;
      cyc();
      check_eq("fl_valid", {31'b0, inst_valid}, 32'd0);
      check_eq("fl_pc", cache_addr, 32'h100);
      flush = 1'b0;
      memlog.delete();
      r0 = rep_cnt;
      wait_valid(40, n);
      check_eq("miss_latency", n, 32'd8);
      check_eq("miss_valid", {31'b0, inst_valid}, 32'd1);
      check_eq("miss_inst", inst, 32'h0010_0093);
      check_eq("miss_inst_pc", inst_pc, 32'h100);
      check_eq("miss_rep_cnt", rep_cnt - r0, 32'd1);
      check_eq("miss_rep_addr", rep_addr, 32'h100);
      check_eq("miss_rep_data", rep_data, 32'h0010_0093);
      check_eq("miss_req_cnt", memlog.size(), 32'd4);
      for (int i = 0; i < 4; i++) check_eq("miss_req_addr", memlog[i], 32'h100 + i);
      check_eq("miss_next_pc", cache_addr, 32'h104);

      // grant withheld three cycles with the third byte pending
      memlog.delete();
      cyc();
      check_eq("gnt_req", {31'b0, mem_req}, 32'd1);
      check_eq("gnt_addr0", mem_addr, 32'h104);
      cyc();
      check_eq("gnt_addr1", mem_addr, 32'h105);
      cyc();
      mem_gnt = 1'b0;
      repeat (3) begin
         check_eq("gnt_hold_addr", mem_addr, 32'h106);
         check_eq("gnt_hold_req", {31'b0, mem_req}, 32'd1);
         cyc();
      end
      check_eq("gnt_hold_addr_last", mem_addr, 32'h106);
      mem_gnt = 1'b1;
      wait_valid(40, n);
      check_eq("gnt_inst", inst, 32'h1817_1615);
      check_eq("gnt_inst_pc", inst_pc, 32'h104);
      check_eq("gnt_req_cnt", memlog.size(), 32'd4);
      check_eq("gnt_req_addr3", memlog[3], 32'h107);

      // flush with two bytes outstanding
      mem_hold = 1'b1;
      memlog.delete();
      r0 = rep_cnt;
      repeat (3) cyc();
      check_eq("ab_addr", mem_addr, 32'h10A);
      mem_gnt = 1'b0;
      flush   = 1'b1;
      target  = 32'h200;
      cyc();
      check_eq("ab_req", {31'b0, mem_req}, 32'd0);
      check_eq("ab_pc", cache_addr, 32'h200);
      check_eq("ab_valid", {31'b0, inst_valid}, 32'd0);
      flush    = 1'b0;
      mem_gnt  = 1'b1;
      mem_hold = 1'b0;
      wait_valid(40, n);
      check_eq("ab_latency", n, 32'd10);
      check_eq("ab_inst", inst, 32'h1413_1211);
      check_eq("ab_inst_pc", inst_pc, 32'h200);
      check_eq("ab_rep_cnt", rep_cnt - r0, 32'd1);
      check_eq("ab_rep_addr", rep_addr, 32'h200);
      check_eq("ab_req_cnt", memlog.size(), 32'd6);
      check_eq("ab_req_addr2", memlog[2], 32'h200);

      // stall on a hit, then flush together with stall
      all_hit = 1'b1;
      stall   = 1'b1;
      repeat (4) begin
         cyc();
         check_eq("st_inst_pc", inst_pc, 32'h200);
         check_eq("st_inst", inst, 32'h1413_1211);
         check_eq("st_pc", cache_addr, 32'h204);
         check_eq("st_valid", {31'b0, inst_valid}, 32'd1);
      end
      flush  = 1'b1;
      target = 32'h300;
      cyc();
      check_eq("stfl_pc", cache_addr, 32'h300);
      check_eq("stfl_valid", {31'b0, inst_valid}, 32'd0);
      flush = 1'b0;
      stall = 1'b0;
      cyc();
      check_eq("stfl_inst_pc", inst_pc, 32'h300);
      check_eq("stfl_inst", inst, 32'h13);
      check_eq("stfl_next", cache_addr, 32'h304);

      // asynchronous reset in the middle of a miss
      all_hit  = 1'b0;
      mem_hold = 1'b1;
      r0       = rep_cnt;
      cyc();
      check_eq("rm_req", {31'b0, mem_req}, 32'd1);
      cyc();
      check_eq("rm_addr", mem_addr, 32'h305);
      rst = 1'b1;
      #1;
      check_eq("rm_req_clr", {31'b0, mem_req}, 32'd0);
      check_eq("rm_pc", cache_addr, 32'h0);
      check_eq("rm_valid", {31'b0, inst_valid}, 32'd0);
      check_eq("rm_inst", inst, 32'h0);
      check_eq("rm_inst_pc", inst_pc, 32'h0);
      check_eq("rm_replace", {31'b0, cache_replace}, 32'd0);
      pend.delete();
      repeat (2) cyc();
      check_eq("rm_rep_cnt", rep_cnt - r0, 32'd0);
      rst      = 1'b0;
      mem_hold = 1'b0;
      all_hit  = 1'b1;
      cyc();
      check_eq("rm_after_valid", {31'b0, inst_valid}, 32'd1);
      check_eq("rm_after_pc", inst_pc, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
